// File: rtl/sprite_store_pkg.sv
// Shared types and elaboration helpers for the multi-port sprite store.
package sprite_store_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_LOAD    = 2'd1;
    localparam state_t ST_DONE    = 2'd2;
    localparam state_t ST_DISCARD = 2'd3;

    function automatic bit pix_bits_legal(input int unsigned pb);
        return (pb == 1) || (pb == 2) || (pb == 4) || (pb == 8);
    endfunction

    function automatic int unsigned calc_ppb(input int unsigned pb);
        return (pb == 0) ? 1 : 8 / pb;
    endfunction

    function automatic int unsigned calc_sprite_bytes(input int unsigned w, input int unsigned h,
                                                      input int unsigned pb);
        return (w * h) / calc_ppb(pb);
    endfunction

    // Address widths never collapse to zero bits, even for single-entry dimensions.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_ram_1w1r.sv
// Byte RAM with one write port and one synchronous read-first read port.
module sprite_ram_1w1r #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register samples the array before any same-edge write lands.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sprite_store_mp.sv
// Multi-port sprite pixel store: byte-stream loader FSM plus NUM_RD unpacking read ports.
module sprite_store_mp
    import sprite_store_pkg::*;
#(
    parameter int unsigned SPRITE_NUM = 8,
    parameter int unsigned SPRITE_W   = 32,
    parameter int unsigned SPRITE_H   = 32,
    parameter int unsigned PIXEL_BITS = 4,
    parameter int unsigned NUM_RD     = 2,
    localparam int unsigned SEL_W     = clog2_min1(SPRITE_NUM),
    localparam int unsigned PA_W      = clog2_min1(SPRITE_W * SPRITE_H)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [7:0]                   s_data,
    input  logic                         s_last,
    output logic                         load_done,
    output logic                         load_err,
    output logic [SPRITE_NUM-1:0]        sprite_valid,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*SEL_W-1:0]      rd_sprite,
    input  logic [NUM_RD*PA_W-1:0]       rd_addr,
    output logic [NUM_RD*PIXEL_BITS-1:0] rd_data
);

    localparam int unsigned PPB          = calc_ppb(PIXEL_BITS);
    localparam int unsigned SPRITE_PIX   = SPRITE_W * SPRITE_H;
    localparam int unsigned SPRITE_BYTES = calc_sprite_bytes(SPRITE_W, SPRITE_H, PIXEL_BITS);
    localparam int unsigned BA_W         = clog2_min1(SPRITE_BYTES);
    localparam int unsigned OFF_W        = clog2_min1(PPB);
    localparam int unsigned DEPTH        = SPRITE_NUM * SPRITE_BYTES;
    localparam int unsigned AW           = clog2_min1(DEPTH);
    localparam logic [BA_W-1:0] LAST_BADDR = BA_W'(SPRITE_BYTES - 1);

    if (!pix_bits_legal(PIXEL_BITS)) begin : g_bad_pixel_bits
        $error("sprite_store_mp: PIXEL_BITS must be 1, 2, 4 or 8");
    end

    state_t                state_q, state_d;
    logic [BA_W-1:0]       baddr_q, baddr_d;
    logic [SEL_W-1:0]      idx_q, idx_d;
    logic [SPRITE_NUM-1:0] sprite_valid_q, sprite_valid_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic                  s_ready_q, s_ready_d;

    logic                  xfer;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [SEL_W-1:0]      hdr_idx;
    logic                  hdr_ok;

    assign xfer    = s_valid && s_ready_q;
    assign hdr_idx = s_data[SEL_W-1:0];
    assign hdr_ok  = 32'(hdr_idx) < SPRITE_NUM;
    assign waddr   = AW'(idx_q) * AW'(SPRITE_BYTES) + AW'(baddr_q);

    // Loader FSM; baddr doubles as the byte counter in DISCARD.
    always_comb begin
        state_d        = state_q;
        baddr_d        = baddr_q;
        idx_d          = idx_q;
        sprite_valid_d = sprite_valid_q;
        load_done_d    = 1'b0;
        load_err_d     = 1'b0;
        we             = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    idx_d   = hdr_idx;
                    baddr_d = '0;
                    if (hdr_ok) begin
                        sprite_valid_d[hdr_idx] = 1'b0;
                        state_d                 = ST_LOAD;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                    if (s_last) begin
                        state_d    = ST_IDLE;
                        load_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    we      = 1'b1;
                    baddr_d = baddr_q + BA_W'(1);
                    if (baddr_q == LAST_BADDR) begin
                        state_d               = ST_DONE;
                        sprite_valid_d[idx_q] = 1'b1;
                        load_done_d           = 1'b1;
                    end else if (s_last) begin
                        state_d    = ST_IDLE;
                        load_err_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_DISCARD: begin
                if (xfer) begin
                    baddr_d = baddr_q + BA_W'(1);
                    if (s_last || (baddr_q == LAST_BADDR)) begin
                        state_d    = ST_IDLE;
                        load_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        s_ready_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            baddr_q        <= '0;
            idx_q          <= '0;
            sprite_valid_q <= '0;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            s_ready_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            baddr_q        <= baddr_d;
            idx_q          <= idx_d;
            sprite_valid_q <= sprite_valid_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
            s_ready_q      <= s_ready_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign sprite_valid = sprite_valid_q;

    // One RAM copy per read port; all copies share the loader write path.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [SEL_W-1:0]      sel;
        logic [PA_W-1:0]       pa;
        logic                  in_rng;
        logic [AW-1:0]         raddr;
        logic [7:0]            rbyte;
        logic [PIXEL_BITS-1:0] pix;
        logic                  rd_vld_q, rd_vld_d;
        logic [OFF_W-1:0]      rd_off_q, rd_off_d;

        assign sel = rd_sprite[k*SEL_W +: SEL_W];
        assign pa  = rd_addr[k*PA_W +: PA_W];

        always_comb begin
            in_rng   = (32'(sel) < SPRITE_NUM) && (32'(pa) < SPRITE_PIX);
            raddr    = '0;
            rd_vld_d = rd_vld_q;
            rd_off_d = rd_off_q;
            if (in_rng) begin
                raddr = AW'(sel) * AW'(SPRITE_BYTES) + AW'(32'(pa) / PPB);
            end
            if (rd_en[k]) begin
                rd_vld_d = in_rng;
                rd_off_d = OFF_W'(32'(pa) % PPB);
            end
        end

        sprite_ram_1w1r #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (we),
            .waddr (waddr),
            .wdata (s_data),
            .re    (rd_en[k]),
            .raddr (raddr),
            .rdata (rbyte)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_vld_q <= 1'b0;
                rd_off_q <= '0;
            end else begin
                rd_vld_q <= rd_vld_d;
                rd_off_q <= rd_off_d;
            end
        end

        // Offset 0 sits in the most-significant pixel field of the byte.
        always_comb begin
            pix = PIXEL_BITS'(rbyte >> ((PPB - 1 - 32'(rd_off_q)) * PIXEL_BITS));
        end

        assign rd_data[k*PIXEL_BITS +: PIXEL_BITS] = rd_vld_q ? pix : '0;
    end

endmodule

// File: tb/tb_sprite_store_mp.sv
// Scoreboard bench for sprite_store_mp: 4x(4x2 @4bpp) main instance plus a 3-slot instance.
module tb_sprite_store_mp;

    localparam int unsigned SN = 4, SW = 4, SH = 2, PB = 4, NR = 2;
    localparam int unsigned SEL_W = 2, PA_W = 3;
    localparam int EV_DONE = 1, EV_ERR = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic              s_valid = 1'b0, s_last = 1'b0, s_ready, load_done, load_err;
    logic [7:0]        s_data = '0;
    logic [SN-1:0]     sprite_valid;
    logic [NR-1:0]     rd_en = '0;
    logic [NR*SEL_W-1:0] rd_sprite = '0;
    logic [NR*PA_W-1:0]  rd_addr = '0;
    logic [NR*PB-1:0]    rd_data;

    logic        s3_valid = 1'b0, s3_last = 1'b0, s3_ready, load_done3, load_err3;
    logic [7:0]  s3_data = '0;
    logic [2:0]  sprite_valid3;
    logic [0:0]  rd3_en = '0;
    logic [1:0]  rd3_sprite = '0;
    logic [2:0]  rd3_addr = '0;
    logic [3:0]  rd3_data;

    int n_chk = 0;
    int n_fail = 0;
    int exp_evt[$];
    int exp_evt3[$];
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic pend0 = 1'b0, pend1 = 1'b0;

    sprite_store_mp #(
        .SPRITE_NUM(SN), .SPRITE_W(SW), .SPRITE_H(SH), .PIXEL_BITS(PB), .NUM_RD(NR)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .load_done(load_done), .load_err(load_err),
        .sprite_valid(sprite_valid), .rd_en(rd_en), .rd_sprite(rd_sprite),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    sprite_store_mp #(
        .SPRITE_NUM(3), .SPRITE_W(SW), .SPRITE_H(SH), .PIXEL_BITS(PB), .NUM_RD(1)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .s_valid(s3_valid), .s_ready(s3_ready), .s_data(s3_data),
        .s_last(s3_last), .load_done(load_done3), .load_err(load_err3),
        .sprite_valid(sprite_valid3), .rd_en(rd3_en), .rd_sprite(rd3_sprite),
        .rd_addr(rd3_addr), .rd_data(rd3_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Present one byte and hold it until the edge that transfers it.
    task automatic send(input int which, input logic [7:0] d, input logic last);
        int   waited;
        logic rdy;
        waited = 0;
        if (which == 0) begin
            s_valid = 1'b1; s_data = d; s_last = last;
        end else begin
            s3_valid = 1'b1; s3_data = d; s3_last = last;
        end
        forever begin
            @(negedge clk);
            rdy = (which == 0) ? s_ready : s3_ready;
            @(posedge clk);
            if (rdy) break;
            waited++;
            if (waited > 20) begin
                chk("s_ready_timeout", 32'(rdy), 32'd1);
                break;
            end
        end
        #1;
    endtask

    task automatic idle();
        s_valid = 1'b0; s_last = 1'b0;
        s3_valid = 1'b0; s3_last = 1'b0;
    endtask

    // Bytes are left-aligned in 'bytes'; s_last optionally on the final one.
    task automatic frame(input int which, input logic [39:0] bytes, input int n, input bit last);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = bytes[39-8*i -: 8];
            send(which, b, last && (i == n - 1));
        end
        idle();
    endtask

    task automatic rd(input int port, input int spr, input int addr, input logic [3:0] exp);
        rd_en[port] = 1'b1;
        rd_sprite[port*SEL_W +: SEL_W] = SEL_W'(spr);
        rd_addr[port*PA_W +: PA_W] = PA_W'(addr);
        if (port == 0) q0.push_back(exp); else q1.push_back(exp);
        @(posedge clk); #1;
        rd_en[port] = 1'b0;
    endtask

    task automatic rd3(input int spr, input int addr, input logic [3:0] exp, input string name);
        rd3_en = 1'b1; rd3_sprite = 2'(spr); rd3_addr = 3'(addr);
        @(posedge clk); #1;
        rd3_en = 1'b0;
        chk(name, 32'(rd3_data), 32'(exp));
    endtask

    always @(posedge clk) begin
        pend0 <= rd_en[0];
        pend1 <= rd_en[1];
    end

    // Monitor: pops the expected read data and load events as the DUTs present them.
    always @(negedge clk) begin : mon
        int         got;
        int         e;
        logic [3:0] x;
        if (pend0) begin
            if (q0.size() == 0) chk("rd0_unexpected", 32'd1, 32'd0);
            else begin x = q0.pop_front(); chk("rd0_data", 32'(rd_data[3:0]), 32'(x)); end
        end
        if (pend1) begin
            if (q1.size() == 0) chk("rd1_unexpected", 32'd1, 32'd0);
            else begin x = q1.pop_front(); chk("rd1_data", 32'(rd_data[7:4]), 32'(x)); end
        end
        if (load_done || load_err) begin
            got = load_err ? EV_ERR : EV_DONE;
            if (load_done && load_err) chk("evt_both", 32'd1, 32'd0);
            if (exp_evt.size() == 0) chk("evt_unexpected", 32'(got), 32'd0);
            else begin
                e = exp_evt.pop_front();
                chk("evt_kind", 32'(got), 32'(e));
                if (got == EV_DONE) chk("s_ready_in_done", 32'(s_ready), 32'd0);
            end
        end
        if (load_done3 || load_err3) begin
            got = load_err3 ? EV_ERR : EV_DONE;
            if (exp_evt3.size() == 0) chk("evt3_unexpected", 32'(got), 32'd0);
            else begin
                e = exp_evt3.pop_front();
                chk("evt3_kind", 32'(got), 32'(e));
                if (got == EV_DONE) chk("s3_ready_in_done", 32'(s3_ready), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_sprite_valid", 32'(sprite_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_pulses", 32'({load_done, load_err}), 32'd0);
        chk("rst_s3_ready", 32'(s3_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic load and sequential pixel reads
        exp_evt.push_back(EV_DONE);
        frame(0, 40'h00_12_34_56_78, 5, 1'b1);
        chk("load_done_after_last", 32'(load_done), 32'd1);
        @(posedge clk); #1;
        chk("valid_after_load0", 32'(sprite_valid), 32'b0001);
        for (int p = 0; p < 8; p++) rd(0, 0, p, 4'(p + 1));

        // Dual port same-cycle reads, then hold
        exp_evt.push_back(EV_DONE);
        frame(0, 40'h01_AA_BB_CC_DD, 5, 1'b1);
        @(posedge clk); #1;
        chk("valid_after_load1", 32'(sprite_valid), 32'b0011);
        rd_en = 2'b11; rd_sprite = {2'd1, 2'd0}; rd_addr = {3'd3, 3'd3};
        q0.push_back(4'h4); q1.push_back(4'hB);
        @(posedge clk); #1;
        rd_en = 2'b00; rd_sprite = {2'd3, 2'd2}; rd_addr = {3'd0, 3'd0};
        repeat (3) @(posedge clk);
        #1;
        chk("rd_hold", 32'(rd_data), 32'hB4);

        // Early s_last aborts the reload of sprite 0
        exp_evt.push_back(EV_ERR);
        frame(0, 40'h00_9A_BC_00_00, 3, 1'b1);
        chk("load_err_after_abort", 32'(load_err), 32'd1);
        @(posedge clk); #1;
        chk("valid_after_abort", 32'(sprite_valid), 32'b0010);
        rd(0, 0, 0, 4'h9);
        rd(0, 0, 3, 4'hC);
        rd(0, 0, 4, 4'h5);

        // Header upper bits ignored: 07 selects slot 3
        exp_evt.push_back(EV_DONE);
        frame(0, 40'h07_11_22_33_44, 5, 1'b1);
        @(posedge clk); #1;
        chk("valid_after_hdr07", 32'(sprite_valid), 32'b1010);
        rd(1, 3, 7, 4'h4);

        // Out-of-range header on the 3-slot instance is discarded
        exp_evt3.push_back(EV_ERR);
        frame(1, 40'h03_01_02_03_04, 5, 1'b0);
        chk("discard_err_on_4th", 32'(load_err3), 32'd1);
        @(posedge clk); #1;
        chk("valid3_after_discard", 32'(sprite_valid3), 32'd0);
        exp_evt3.push_back(EV_DONE);
        frame(1, 40'h02_5A_00_00_00, 5, 1'b1);
        @(posedge clk); #1;
        chk("valid3_after_load2", 32'(sprite_valid3), 32'b100);
        rd3(2, 0, 4'h5, "rd3_sprite2_pix0");
        rd3(2, 1, 4'hA, "rd3_sprite2_pix1");
        rd3(3, 0, 4'h0, "rd3_oor_sprite");

        // Read-first collision while reloading sprite 1
        exp_evt.push_back(EV_DONE);
        send(0, 8'h01, 1'b0);
        rd_en[1] = 1'b1; rd_sprite[3:2] = 2'd1; rd_addr[5:3] = 3'd0;
        q1.push_back(4'hA);
        send(0, 8'hEE, 1'b0);
        rd_en[1] = 1'b0;
        send(0, 8'hFF, 1'b0);
        send(0, 8'h00, 1'b0);
        send(0, 8'h11, 1'b1);
        idle();
        @(posedge clk); #1;
        rd(1, 1, 0, 4'hE);
        rd(1, 1, 1, 4'hE);
        chk("valid_after_reload1", 32'(sprite_valid), 32'b1010);

        // Reset in the middle of a load
        send(0, 8'h02, 1'b0);
        send(0, 8'h55, 1'b0);
        send(0, 8'h66, 1'b0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", 32'(s_ready), 32'd1);
        chk("midrst_sprite_valid", 32'(sprite_valid), 32'd0);
        chk("midrst_rd_data", 32'(rd_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_evt.push_back(EV_DONE);
        frame(0, 40'h02_01_23_45_67, 5, 1'b1);
        @(posedge clk); #1;
        chk("valid_after_rst_load", 32'(sprite_valid), 32'b0100);
        rd(0, 2, 5, 4'h5);
        rd(1, 1, 0, 4'hE);

        repeat (4) @(posedge clk);
        #1;
        chk("rd0_queue_drained", 32'(q0.size()), 32'd0);
        chk("rd1_queue_drained", 32'(q1.size()), 32'd0);
        chk("evt_queue_drained", 32'(exp_evt.size()), 32'd0);
        chk("evt3_queue_drained", 32'(exp_evt3.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_store_mp.md
Name: sprite_store_mp

Overview:
Parametrised multi-port sprite pixel store, the successor to the single-port sprite storage. A byte stream from the SPI driver is loaded by an internal FSM: one header byte selects the sprite, and the following bytes are packed pixel data. NUM_RD independent read ports serve the renderer channels. Each read port has its own sprite select and pixel address. Per-sprite valid flags show which sprites hold complete images.

Parameters:
SPRITE_NUM, 8, number of sprite slots
SPRITE_W, 32, sprite width in pixels
SPRITE_H, 32, sprite height in pixels
PIXEL_BITS, 4, bits per pixel; legal values 1, 2, 4, 8
NUM_RD, 2, number of read ports

Derived:
- PPB = 8/PIXEL_BITS
- SPRITE_PIX = SPRITE_W*SPRITE_H
- SPRITE_BYTES = SPRITE_PIX/PPB
- SEL_W = $clog2(SPRITE_NUM)
- PA_W = $clog2(SPRITE_PIX)
- BA_W = $clog2(SPRITE_BYTES)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input byte valid
s_ready  out  1  store accepts a byte; transfer when s_valid&&s_ready
s_data  in  8  header byte or packed pixel byte
s_last  in  1  marks final byte of a frame
load_done  out  1  one-cycle pulse: a sprite finished loading
load_err  out  1  one-cycle pulse: frame aborted or header out of range
sprite_valid  out  SPRITE_NUM  per-sprite complete-image flags
rd_en  in  NUM_RD  per-port read enable
rd_sprite  in  NUM_RD*SEL_W  per-port sprite select, packed port 0 in LSBs
rd_addr  in  NUM_RD*PA_W  per-port pixel address, row-major y*SPRITE_W+x
rd_data  out  NUM_RD*PIXEL_BITS  per-port pixel value

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; s_ready=1.
  - load_done=0, load_err=0, sprite_valid=0, rd_data=0.
  - Memory contents are not reset.
- Packing: pixel p lives in byte p/PPB at offset p%PPB. Offset 0 occupies the most-significant PIXEL_BITS of the byte. Example at PIXEL_BITS=4: byte 0x12 gives pixel0=1, pixel1=2.
- FSM IDLE:
  - The accepted byte is the header. Index = s_data[SEL_W-1:0]; upper bits are ignored.
  - If index < SPRITE_NUM: clear sprite_valid[index], set baddr=0, go to LOAD.
  - Otherwise go to DISCARD.
  - If the header itself carries s_last: return to IDLE and pulse load_err.
- FSM LOAD:
  - Each accepted byte writes mem[index][baddr], then baddr++.
  - When the byte is number SPRITE_BYTES-1: go to DONE.
  - s_last on that final byte is expected but not required.
  - If s_last arrives earlier: go to IDLE, pulse load_err; sprite_valid[index] stays 0.
- FSM DONE (one cycle):
  - s_ready=0.
  - Set sprite_valid[index], pulse load_done, go to IDLE.
  - Bytes beyond SPRITE_BYTES after DONE are treated as new headers.
- FSM DISCARD:
  - Absorb bytes until s_last or until SPRITE_BYTES bytes are taken, then go to IDLE and pulse load_err.
  - No memory write and no flag change.
- s_ready is 1 in IDLE, LOAD and DISCARD, and 0 only in DONE. s_data, s_valid and s_last are sampled only on a transfer.
- Read ports:
  - Latency is 1 cycle: rd_data[k] is updated on the edge after rd_en[k]=1 with the pixel at (rd_sprite[k], rd_addr[k]).
  - When rd_en[k]=0, rd_data[k] holds its value.
  - Out-of-range rd_sprite or rd_addr returns 0.
  - Read port behaviour is independent of sprite_valid; gating on sprite_valid is the renderer's job.
- Collision: a read of the byte being written in the same cycle returns the old data (read-first). The new data is visible on the next read.
- All ports may read the same location in the same cycle.
- A reset in the middle of a load aborts the load. No pulse is generated, and the partially written memory is left as is.

Decomposition:
- Package sprite_store_pkg holds:
  - the legal PIXEL_BITS check function;
  - the PPB/SPRITE_BYTES helper functions;
  - the FSM state typedef {IDLE, LOAD, DONE, DISCARD}.
- Sub-module sprite_ram_1w1r: a 1-write/1-read byte RAM of SPRITE_NUM*SPRITE_BYTES bytes with synchronous read-first output.
  - The top replicates it NUM_RD times, with the write path shared by all copies.
  - The top does the pixel unpacking after the RAM read, using a registered offset and registered range-valid bit.

Test Plan (SPRITE_NUM=4, SPRITE_W=4, SPRITE_H=2, PIXEL_BITS=4, NUM_RD=2, so SPRITE_BYTES=4):
- Load: stream 00,12,34,56,78 with s_last on 78.
  - Expect load_done pulse one cycle after 78 and s_ready=0 for that cycle.
  - Expect sprite_valid=0001.
  - Port 0 reads sprite 0, pixels 0..7: returns 1,2,3,4,5,6,7,8, each one cycle after its request.
- Dual port: load sprite 1 with AA,BB,CC,DD.
  - Same cycle: port 0 reads (0,3) and port 1 reads (1,3).
  - Expect 4 and B respectively.
  - Then rd_en=0 on both ports: outputs hold.
- Abort: reload sprite 0 with header 00, then 9A,BC with s_last on BC.
  - Expect load_err pulse and sprite_valid[0]=0.
  - Pixel 0 reads 9; pixel 4 still reads 5.
- Bad header: send 07, which maps to index 3 (valid).
  - Then at SPRITE_NUM=3, header 03 followed by 4 bytes.
  - Expect DISCARD, load_err after the 4th byte, and no flag change.
- Collision: during a reload of sprite 1, read byte 0 of sprite 1 in the cycle it is written with EE.
  - Expect old value A; the next read returns E.
- Reset: assert rst_n=0 mid-LOAD.
  - Expect immediate reset of s_ready=1, sprite_valid=0, rd_data=0.
  - A new full load after release succeeds.
